// File: rtl/keypad_bcd_encoder.sv
// keypad_bcd_encoder
//   Collects up to three decimal digits from a keypad scanner as BCD and, on
//   enter, converts the entry to binary with an iterative reverse
//   double-dabble (one shift-and-correct step per cycle, 10 cycles).
//   Results above 255 saturate to 8'hFF and raise overflow_o.
//
// Parameters
//   CLEAR_ON_DONE : 1 = entry zeroed when a conversion completes, 0 = kept.
//
// Build option
//   KEYPAD_BACKSPACE_EN : when defined, key 0xC drops the last digit entered.
//                         When undefined, 0xC is ignored like 0xD-0xF.
//
// Ports
//   clk_i        in   system clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   key_valid_i  in   key strobe, key_i sampled this cycle
//   key_i[3:0]   in   0-9 digit, A clear, B enter, C backspace, D-F ignored
//   digits_o     out  live entry {hundreds, tens, units}
//   busy_o       out  conversion in progress, keys dropped
//   data_o       out  last converted value, saturated to 8 bits
//   valid_o      out  one-cycle pulse when data_o/overflow_o update
//   overflow_o   out  last conversion exceeded 255

module keypad_bcd_encoder #(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        key_valid_i,
  input  logic [3:0]  key_i,
  output logic [11:0] digits_o,
  output logic        busy_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        overflow_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_ENTER = 4'hB;
  localparam logic [3:0] K_BKSP  = 4'hC;

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [11:0] work;
  logic [9:0]  acc;
  logic [3:0]  iter;

  logic [21:0] shifted;
  logic [11:0] work_nx;
  logic [9:0]  acc_nx;

  // One reverse double-dabble step: shift the BCD word into the binary
  // accumulator, then undo the "+3" of forward double-dabble on any nibble
  // whose top bit was filled from the digit above (value >= 8).
  always_comb begin
    shifted = {work, acc} >> 1;
    acc_nx  = shifted[9:0];
    work_nx = shifted[21:10];
    for (int i = 0; i < 3; i++) begin
      if (shifted[10 + 4*i +: 4] >= 4'd8)
        work_nx[4*i +: 4] = shifted[10 + 4*i +: 4] - 4'd3;
    end
  end

  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      digits_o   <= 12'h000;
      work       <= 12'h000;
      acc        <= 10'd0;
      iter       <= 4'd0;
      data_o     <= 8'h00;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_valid_i) begin
            if (key_i <= 4'd9) begin
              if (cnt != 2'd3) begin
                digits_o <= {digits_o[7:0], key_i};
                cnt      <= cnt + 2'd1;
              end
            end else if (key_i == K_CLEAR) begin
              digits_o   <= 12'h000;
              cnt        <= 2'd0;
              overflow_o <= 1'b0;
            end else if (key_i == K_ENTER) begin
              work  <= digits_o;
              acc   <= 10'd0;
              iter  <= 4'd0;
              state <= S_CONV;
`ifdef KEYPAD_BACKSPACE_EN
            end else if (key_i == K_BKSP) begin
              if (cnt != 2'd0) begin
                digits_o <= {4'h0, digits_o[11:4]};
                cnt      <= cnt - 2'd1;
              end
`endif
            end
          end
        end

        S_CONV: begin
          work <= work_nx;
          acc  <= acc_nx;
          iter <= iter + 4'd1;
          // Last step: publish the result straight from the combinational
          // step so valid_o lands in the DONE cycle.
          if (iter == 4'd9) begin
            state   <= S_DONE;
            valid_o <= 1'b1;
            if (acc_nx > 10'd255) begin
              data_o     <= 8'hFF;
              overflow_o <= 1'b1;
            end else begin
              data_o     <= acc_nx[7:0];
              overflow_o <= 1'b0;
            end
            if (CLEAR_ON_DONE) begin
              digits_o <= 12'h000;
              cnt      <= 2'd0;
            end
          end
        end

        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Self-checking bench for keypad_bcd_encoder: directed test-plan sequences
// with literal expectations, then randomized key traffic. A decimal-level
// model (digit list, phase counter) is compared against the DUT every cycle.

module tb_keypad_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key = 4'h0;
  logic [11:0] digits;
  logic        busy;
  logic [7:0]  data;
  logic        valid;
  logic        overflow;

  int  checks = 0;
  int  failures = 0;
  bit  chk_en = 1'b0;

  keypad_bcd_encoder #(.CLEAR_ON_DONE(1'b1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .key_valid_i(key_valid),
    .key_i      (key),
    .digits_o   (digits),
    .busy_o     (busy),
    .data_o     (data),
    .valid_o    (valid),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int d[3];    // hundreds, tens, units as plain integers
    int cnt;     // digits entered
    int ph;      // 0 idle, 1..11 cycles since enter
    int val;     // decimal value captured at enter
    int data;
    bit ovf;
    bit vld;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.d[0] = 0; r.d[1] = 0; r.d[2] = 0;
    r.cnt = 0; r.ph = 0; r.val = 0; r.data = 0; r.ovf = 0; r.vld = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, bit kv, int k);
    model_t r = s;
    r.vld = 0;
    if (s.ph == 0) begin
      if (kv) begin
        if (k <= 9) begin
          if (s.cnt < 3) begin
            r.d[0] = s.d[1]; r.d[1] = s.d[2]; r.d[2] = k;
            r.cnt = s.cnt + 1;
          end
        end else if (k == 10) begin
          r.d[0] = 0; r.d[1] = 0; r.d[2] = 0; r.cnt = 0; r.ovf = 0;
        end else if (k == 11) begin
          r.val = s.d[0] * 100 + s.d[1] * 10 + s.d[2];
          r.ph = 1;
`ifdef KEYPAD_BACKSPACE_EN
        end else if (k == 12) begin
          if (s.cnt > 0) begin
            r.d[2] = s.d[1]; r.d[1] = s.d[0]; r.d[0] = 0;
            r.cnt = s.cnt - 1;
          end
`endif
        end
      end
    end else begin
      r.ph = s.ph + 1;
      if (r.ph == 11) begin
        r.vld  = 1;
        r.ovf  = (s.val > 255);
        r.data = r.ovf ? 255 : s.val;
        r.d[0] = 0; r.d[1] = 0; r.d[2] = 0; r.cnt = 0;
      end else if (r.ph == 12) begin
        r.ph = 0;
      end
    end
    return r;
  endfunction

  initial m = model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, key_valid, int'(key));
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("digits", int'(digits), m.d[0] * 256 + m.d[1] * 16 + m.d[2]);
      chk("busy",   int'(busy),   (m.ph != 0) ? 1 : 0);
      chk("valid",  int'(valid),  int'(m.vld));
      chk("data",   int'(data),   m.data);
      chk("ovf",    int'(overflow), int'(m.ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digits", int'(digits), 0);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_valid",  int'(valid), 0);
    chk("rst_data",   int'(data), 0);
    chk("rst_ovf",    int'(overflow), 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // 255: in range, exact latency
    press(4'h2); press(4'h5); press(4'h5);
    chk("dig_255", int'(digits), 'h255);
    press(4'hB);
    wait_valid(lat);
    chk("lat_255", lat, 10);
    chk("data_255", int'(data), 'hFF);
    chk("ovf_255", int'(overflow), 0);
    @(negedge clk);
    chk("cleared_255", int'(digits), 0);

    // 256 and 999 overflow, then clear
    press(4'h2); press(4'h5); press(4'h6); press(4'hB);
    wait_valid(lat);
    chk("seen_256", int'(lat > 0), 1);
    chk("data_256", int'(data), 'hFF);
    chk("ovf_256", int'(overflow), 1);
    press(4'h9); press(4'h9); press(4'h9); press(4'hB);
    wait_valid(lat);
    chk("data_999", int'(data), 'hFF);
    chk("ovf_999", int'(overflow), 1);
    press(4'hA);
    chk("ovf_clear", int'(overflow), 0);

    // 042 and empty entry
    press(4'h0); press(4'h4); press(4'h2); press(4'hB);
    wait_valid(lat);
    chk("data_042", int'(data), 'h2A);
    press(4'hB);
    wait_valid(lat);
    chk("seen_empty", int'(lat > 0), 1);
    chk("data_empty", int'(data), 'h00);

    // 4th digit ignored, keys during busy dropped
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("dig_123", int'(digits), 'h123);
    press(4'hB);
    for (int i = 0; i < 3; i++) begin
      press(4'h5);
      chk("busy_drop_dig", int'(digits), 'h123);
    end
    wait_valid(lat);
    chk("data_123", int'(data), 'h7B);

    // reset in the middle of CONVERT
    press(4'h1); press(4'h9); press(4'hB);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", int'(digits), 0);
    chk("mid_rst_busy",   int'(busy), 0);
    chk("mid_rst_data",   int'(data), 0);
    chk("mid_rst_ovf",    int'(overflow), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    press(4'h7); press(4'hB);
    wait_valid(lat);
    chk("data_7", int'(data), 'h07);

    // backspace key
    press(4'h1); press(4'h2); press(4'h3); press(4'hC);
`ifdef KEYPAD_BACKSPACE_EN
    chk("bksp_dig", int'(digits), 'h012);
    press(4'hB);
    wait_valid(lat);
    chk("bksp_data", int'(data), 'h0C);
`else
    chk("no_bksp_dig", int'(digits), 'h123);
    press(4'hA);
`endif

    // randomized traffic, occasional reset
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 65) k = 4'hA;
      else if (r < 80) k = 4'hB;
      else if (r < 90) k = 4'hC;
      else             k = 4'($urandom_range(13, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      press(k);
    end
    repeat (15) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
